reg_file_asy: RTL

- Parametrised register bank for the single-cycle datapath. Generalises the single-bit async-reset D flip-flop to DEPTH words of WIDTH bits.
- One synchronous write port, two combinational read ports, and an optional hardwired-zero register 0.
- Sits between the instruction decoder (addresses), the ALU (read operands) and the writeback mux (write data).

---
 rtl/reg_file_asy.sv | 62 ++++++
 1 files changed

// File: rtl/reg_file_asy.sv
// reg_file_asy: DEPTH x WIDTH register bank, one synchronous write port, two combinational read ports.
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset; all words -> RST_VAL, wr_cnt -> 0
//   clr            synchronous clear, same effect as rst at the next edge; beats we
//   we/waddr/wdata write port
//   raddr1/rdata1  read port 1 (combinational)
//   raddr2/rdata2  read port 2 (combinational)
//   wr_cnt         saturating count of committed writes
// Optional macro REG_FILE_BYPASS_EN: forward wdata to a read port addressing the word being written.
module reg_file_asy #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int ZERO_REG = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    output logic [WIDTH-1:0] rdata1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata2,
    output logic [15:0]      wr_cnt
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic             commit;
    logic [WIDTH-1:0] st1, st2;

    // Writes to the hardwired zero register are neither stored nor counted.
    assign commit = we && (ZERO_REG == 0 || waddr != '0);

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
            wr_cnt <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= RST_VAL;
            wr_cnt <= '0;
        end else if (commit) begin
            mem[waddr] <= wdata;
            if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
        end

    // Register 0 reads zero even when RST_VAL is non-zero.
    assign st1 = (ZERO_REG != 0 && raddr1 == '0) ? '0 : mem[raddr1];
    assign st2 = (ZERO_REG != 0 && raddr2 == '0) ? '0 : mem[raddr2];

`ifdef REG_FILE_BYPASS_EN
    logic fwd;
    assign fwd = commit && !rst && !clr;
    assign rdata1 = (fwd && raddr1 == waddr) ? wdata : st1;
    assign rdata2 = (fwd && raddr2 == waddr) ? wdata : st2;
`else
    assign rdata1 = st1;
    assign rdata2 = st2;
`endif
endmodule
